// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in serial-out shifter with valid/ready load, stallable shift, DONE pulse
// Ports: CLK/RST (async, active-high) clock and reset; DIN/LOAD_VALID/LOAD_READY word load handshake;
//        ENABLE shift enable; Q/Q_Prime registered serial bit and its complement;
//        BUSY high while shifting; DONE one-cycle pulse after the final bit period.
module piso_shift_register #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic             ENABLE,
    output logic             Q,
    output logic             Q_Prime,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, sreg_adv;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_q, q_d, qp_q, done_q, done_d;
    logic             last;
    // The bit on Q is always the head of the shift register, so advancing
    // means shifting toward the head end and presenting the new head.
    function automatic logic head(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction
    assign sreg_adv = MSB_FIRST ? sreg_q << 1 : sreg_q >> 1;
    assign last     = cnt_q == CW'(WIDTH - 1);
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            qp_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qp_q    <= ~q_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            q_d = 1'b0;
            if (LOAD_VALID) begin
                sreg_d  = DIN;
                cnt_d   = '0;
                q_d     = head(DIN);
                state_d = SHIFT;
            end
        end else if (ENABLE) begin
            if (last) begin
                q_d     = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                sreg_d = sreg_adv;
                cnt_d  = cnt_q + CW'(1);
                q_d    = head(sreg_adv);
            end
        end
    end
    always_comb begin
        LOAD_READY = state_q == IDLE;
        BUSY       = state_q == SHIFT;
        Q          = q_q;
        Q_Prime    = qp_q;
        DONE       = done_q;
    end
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: checks MSB-first and LSB-first instances against a queue-based model
module tb_piso_shift_register;
    localparam int W = 8;
    logic         CLK = 1'b0, RST = 1'b0;
    logic [W-1:0] DIN = '0;
    logic         LOAD_VALID = 1'b0, ENABLE = 1'b0;
    logic         rdy_m, q_m, qp_m, busy_m, done_m;
    logic         rdy_l, q_l, qp_l, busy_l, done_l;
    int           checks = 0, errors = 0;
    bit           cmp_en = 1'b0;
    bit           m_busy = 1'b0, m_q_m = 1'b0, m_q_l = 1'b0, m_done = 1'b0;
    bit           qm[$], ql[$];

    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .CLK(CLK), .RST(RST), .DIN(DIN), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy_m),
        .ENABLE(ENABLE), .Q(q_m), .Q_Prime(qp_m), .BUSY(busy_m), .DONE(done_m));
    piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .CLK(CLK), .RST(RST), .DIN(DIN), .LOAD_VALID(LOAD_VALID), .LOAD_READY(rdy_l),
        .ENABLE(ENABLE), .Q(q_l), .Q_Prime(qp_l), .BUSY(busy_l), .DONE(done_l));

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_q_m = 1'b0; m_q_l = 1'b0; m_done = 1'b0;
        qm.delete(); ql.delete();
    endtask

    // Outstanding bits are held as queues in transmit order; Q is whatever was popped last.
    task automatic model_edge();
        if (RST) model_reset();
        else begin
            m_done = 1'b0;
            if (!m_busy) begin
                m_q_m = 1'b0; m_q_l = 1'b0;
                if (LOAD_VALID) begin
                    qm.delete(); ql.delete();
                    for (int i = 0; i < W; i++) begin
                        qm.push_back(DIN[W-1-i]);
                        ql.push_back(DIN[i]);
                    end
                    m_busy = 1'b1;
                    m_q_m = qm.pop_front();
                    m_q_l = ql.pop_front();
                end
            end else if (ENABLE) begin
                if (qm.size() == 0) begin
                    m_busy = 1'b0; m_q_m = 1'b0; m_q_l = 1'b0; m_done = 1'b1;
                end else begin
                    m_q_m = qm.pop_front();
                    m_q_l = ql.pop_front();
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    always @(negedge CLK) if (cmp_en) begin
        check("msb_outputs", {27'd0, q_m, qp_m, busy_m, done_m, rdy_m},
              {27'd0, m_q_m, ~m_q_m, m_busy, m_done, ~m_busy});
        check("lsb_outputs", {27'd0, q_l, qp_l, busy_l, done_l, rdy_l},
              {27'd0, m_q_l, ~m_q_l, m_busy, m_done, ~m_busy});
    end

    // Sends one word; collects the bit shown in each distinct bit period and the DONE cycle index.
    task automatic run_word(input logic [W-1:0] din, input int sa, input int sl,
                            output logic [W-1:0] got_m, output logic [W-1:0] got_l,
                            output int done_at, output int busy_cnt);
        done_at = -1; busy_cnt = 0;
        LOAD_VALID = 1'b1; DIN = din; ENABLE = 1'b1;
        cyc();
        got_m = {{(W-1){1'b0}}, q_m};
        got_l = {{(W-1){1'b0}}, q_l};
        busy_cnt += int'(busy_m);
        for (int n = 1; n < 40; n++) begin
            LOAD_VALID = 1'($urandom);
            DIN = W'($urandom);
            ENABLE = !(n >= sa && n < sa + sl);
            cyc();
            busy_cnt += int'(busy_m);
            if (ENABLE && busy_m) begin
                got_m = {got_m[W-2:0], q_m};
                got_l = {got_l[W-2:0], q_l};
            end
            if (done_m) begin
                done_at = n + 1;
                break;
            end
        end
        LOAD_VALID = 1'b0;
        check("done_seen", done_at != -1, 1);
    endtask

    initial begin
        logic [W-1:0] gm, gl;
        int da, bc;
        #2 RST = 1'b1;
        model_reset();
        #1;
        check("async_reset_outputs", {q_m, qp_m, busy_m, done_m, rdy_m}, 5'b01001);
        repeat (2) cyc();
        RST = 1'b0;
        cmp_en = 1'b1;
        cyc();
        run_word(8'hA5, 100, 0, gm, gl, da, bc);
        check("a5_msb_stream", gm, 8'hA5);
        check("a5_lsb_stream", gl, 8'hA5);
        check("a5_done_cycle", da, 9);
        check("a5_busy_cycles", bc, 8);
        cyc();
        run_word(8'h01, 100, 0, gm, gl, da, bc);
        check("01_lsb_stream", gl, 8'h80);
        check("01_msb_stream", gm, 8'h01);
        cyc();
        run_word(8'hF0, 3, 3, gm, gl, da, bc);
        check("stall_msb_stream", gm, 8'hF0);
        check("stall_done_cycle", da, 12);
        check("stall_busy_cycles", bc, 11);
        cyc();
        run_word(8'h81, 100, 0, gm, gl, da, bc);
        check("b2b_first_stream", gm, 8'h81);
        run_word(8'h7E, 100, 0, gm, gl, da, bc);
        check("b2b_second_stream", gm, 8'h7E);
        check("b2b_second_done", da, 9);
        cyc();
        LOAD_VALID = 1'b1; DIN = 8'hC3; ENABLE = 1'b1;
        cyc();
        LOAD_VALID = 1'b0;
        repeat (4) cyc();
        check("c3_bit4_on_q", q_m, 1'b0);
        #2 RST = 1'b1;
        model_reset();
        #1;
        check("midshift_reset_outputs", {q_m, qp_m, busy_m, done_m, rdy_m}, 5'b01001);
        cyc();
        RST = 1'b0;
        cyc();
        check("no_done_after_reset", done_m, 1'b0);
        run_word(8'h3C, 100, 0, gm, gl, da, bc);
        check("post_reset_stream", gm, 8'h3C);
        check("post_reset_done", da, 9);
        for (int i = 0; i < 600; i++) begin
            LOAD_VALID = ($urandom_range(0, 1) == 1);
            ENABLE = ($urandom_range(0, 3) != 0);
            DIN = W'($urandom);
            RST = ($urandom_range(0, 99) == 0);
            cyc();
        end
        RST = 1'b0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
